pe_edge_feeder: RTL and testbench
=================================

# pe_edge_feeder

Operand feeder sitting directly upstream of a `processing_element` on the array edge. It buffers (x, w) operand pairs in a small FIFO, waits a programmable skew delay after a global `go`, then issues exactly `len_i` pairs to the PE. Each issue is gated by the PE's `stall`, and each issued operand is held stable on `x_o`/`w_o` until the next issue. One instance drives each edge row; the skew parameter produces the diagonal wavefront.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `SKEW`, 0: cycles between `go` and first issue eligibility (row index on the edge).
- `LEN_W`, 16: width of the transfer length.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: push `{wr_x, wr_w}` into the FIFO.
- `wr_x` in 32 (`word_t`): x operand to push.
- `wr_w` in 32 (`word_t`): w operand to push.
- `full` out 1: FIFO full.
- `empty` out 1: FIFO empty.
- `fill` out `$clog2(DEPTH)+1`: current FIFO occupancy.
- `overflow` out 1: sticky flag, set by a push while full; cleared only by `rst`.
- `go` in 1: start a transfer. Sampled only in IDLE.
- `len_i` in `LEN_W`: number of pairs to issue. Latched on an accepted `go`.
- `pe_stall` in 1: `stall` from the downstream PE.
- `x_o` out 32: to PE `x_i`.
- `w_o` out 32: to PE `w_i`.
- `input_start` out 1: to PE `input_start`.
- `busy` out 1: high in SKEW or STREAM.
- `done` out 1: one-cycle pulse when the transfer completes.

## Operation
- **FSM states:** IDLE, SKEW, STREAM, DONE.
- **IDLE:**
  - On `go` with `len_i==0`, go to DONE.
  - On `go` with `SKEW==0`, go to STREAM.
  - On `go` otherwise, go to SKEW with skew counter loaded to `SKEW-1`.
- **SKEW:** decrement the counter each cycle; at 0, go to STREAM.
- **STREAM:**
  - `issue = !empty && !pe_stall`.
  - On issue: pop the FIFO head and decrement the remaining count.
  - When the last pair issues, go to DONE.
- **DONE:** `done=1` for one cycle, then IDLE.
- **Outputs:**
  - `input_start = issue`, combinational.
  - In an issue cycle, `x_o`/`w_o` = FIFO head, combinational. The head is also captured into hold registers.
  - In all other cycles, `x_o`/`w_o` = hold registers. This keeps operands stable while the PE is in its mult state.
- **FIFO:**
  - Circular buffer with `$clog2(DEPTH)`-bit read/write pointers that wrap modulo `DEPTH`.
  - A push while full is dropped and sets `overflow`.
  - A push and pop in the same cycle while full is accepted; `fill` is unchanged.
  - A push and pop in the same cycle while empty is impossible, because issue requires `!empty`.
  - No write-to-read bypass.
- **Pushes:** accepted in every state, including during a transfer.
- **Starvation:** while in STREAM with the FIFO empty, no issue occurs and the remaining count is held.
- **`go` outside IDLE:** ignored.
- **Reset, including mid-transfer:**
  - FSM returns to IDLE; pointers, `fill`, hold registers and counters clear; `overflow` clears.
  - Reset values: `x_o=0`, `w_o=0`, `input_start=0`, `busy=0`, `done=0`, `empty=1`, `full=0`, `fill=0`, `overflow=0`.

## Timing
- A push in cycle t is visible (`empty` low, `fill` updated) in cycle t+1.
- `go` accepted in cycle t: STREAM is entered in cycle t+1+`SKEW`, which is the earliest issue cycle.
- Issue has zero latency from `pe_stall` falling: `input_start` rises in the same cycle.
- Back-to-back issues follow the PE cadence: one issue per PE start/send window.
- `done` is high in the cycle after the final issue. `busy` falls in that same cycle.
- `len_i==0`: `done` in cycle t+1, no issues.

## Configuration
- **`PE_FEEDER_STATS_EN` defined:** adds two 32-bit output ports.
  - `stall_cycles` counts STREAM cycles with `!empty && pe_stall`.
  - `starve_cycles` counts STREAM cycles with `empty`.
  - Both clear on `rst` and on an accepted `go`, and saturate at all-ones.
- **Not defined:** the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset mid-STREAM with 3 of 8 pairs issued, `fill=5` → next cycle: IDLE, `fill=0`, `x_o=0`, `input_start=0`, `overflow=0`.
- `SKEW=3`, push 4 pairs (x=1.0..4.0), `go` at cycle 10 with `len_i=4`, `pe_stall=0` → first `input_start` at cycle 14, x_o=0x3F800000; `done` at cycle 18.
- `pe_stall` held high for 3 cycles after each issue → `x_o`/`w_o` are held constant across the stall; 4 issues total; `done` follows the 4th issue by 1 cycle.
- `DEPTH=4`: 5 pushes while idle → `full=1`, `fill=4`, `overflow=1`, 5th pair absent from the issued stream.
- `len_i=6` with 2 pairs buffered → 2 issues, then stall with `busy=1`. Push 4 more → the 4 remaining pairs issue, then `done`. With `PE_FEEDER_STATS_EN`, `starve_cycles` equals the empty-wait cycle count.
- `len_i=0` → `done` pulses at cycle t+1, no `input_start`, FIFO untouched.

Source files
------------

// File: rtl/pe_edge_feeder.sv
// Skewed operand feeder: FIFO of (x, w) pairs issued to an edge PE after a go.
// Define PE_FEEDER_STATS_EN to add stall_cycles / starve_cycles counters.
module pe_edge_feeder #(
  parameter int DEPTH = 16,
  parameter int SKEW  = 0,
  parameter int LEN_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [31:0]              wr_x,
  input  logic [31:0]              wr_w,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overflow,
  input  logic                     go,
  input  logic [LEN_W-1:0]         len_i,
  input  logic                     pe_stall,
  output logic [31:0]              x_o,
  output logic [31:0]              w_o,
  output logic                     input_start,
  output logic                     busy,
  output logic                     done
`ifdef PE_FEEDER_STATS_EN
  ,
  output logic [31:0]              stall_cycles,
  output logic [31:0]              starve_cycles
`endif
);

  typedef logic [31:0] word_t;

  localparam int AW = $clog2(DEPTH);
  localparam int SW = (SKEW > 1) ? $clog2(SKEW) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SKEW,
    S_STREAM,
    S_DONE
  } state_t;

  state_t state, state_n;

  word_t mem_x [DEPTH];
  word_t mem_w [DEPTH];

  logic [AW-1:0]    wp, rp;
  logic [SW-1:0]    skew_cnt;
  logic [LEN_W-1:0] rem;
  word_t            hold_x, hold_w;
  logic             issue, push, go_acc;

  assign empty  = (fill == '0);
  assign full   = (fill == (AW+1)'(DEPTH));
  assign go_acc = (state == S_IDLE) && go;
  assign issue  = (state == S_STREAM) && !empty && !pe_stall;
  // a full FIFO still takes a push when the head leaves in the same cycle
  assign push   = wr_en && (!full || issue);

  assign input_start = issue;
  assign x_o  = issue ? mem_x[rp] : hold_x;
  assign w_o  = issue ? mem_w[rp] : hold_w;
  assign busy = (state == S_SKEW) || (state == S_STREAM);
  assign done = (state == S_DONE);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (go) begin
          if (len_i == '0)    state_n = S_DONE;
          else if (SKEW == 0) state_n = S_STREAM;
          else                state_n = S_SKEW;
        end
      end
      S_SKEW:
        if (skew_cnt == '0) state_n = S_STREAM;
      S_STREAM:
        if (issue && rem == LEN_W'(1)) state_n = S_DONE;
      S_DONE:
        state_n = S_IDLE;
      default:
        state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_x[wp] <= wr_x;
      mem_w[wp] <= wr_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wp       <= '0;
      rp       <= '0;
      fill     <= '0;
      overflow <= 1'b0;
      skew_cnt <= '0;
      rem      <= '0;
      hold_x   <= '0;
      hold_w   <= '0;
    end else begin
      state <= state_n;
      if (push) wp <= wp + 1'b1;
      if (issue) begin
        rp     <= rp + 1'b1;
        rem    <= rem - 1'b1;
        hold_x <= mem_x[rp];
        hold_w <= mem_w[rp];
      end
      case ({push, issue})
        2'b10:   fill <= fill + (AW+1)'(1);
        2'b01:   fill <= fill - (AW+1)'(1);
        default: fill <= fill;
      endcase
      if (wr_en && full && !issue) overflow <= 1'b1;
      if (go_acc) begin
        rem      <= len_i;
        skew_cnt <= SW'(SKEW - 1);
      end else if (state == S_SKEW) begin
        skew_cnt <= skew_cnt - 1'b1;
      end
    end
  end

`ifdef PE_FEEDER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || go_acc) begin
      stall_cycles  <= '0;
      starve_cycles <= '0;
    end else if (state == S_STREAM) begin
      if (empty && starve_cycles != '1)
        starve_cycles <= starve_cycles + 32'd1;
      if (!empty && pe_stall && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_edge_feeder.sv
// Randomised self-checking bench for pe_edge_feeder against a queue model.
module tb_pe_edge_feeder;

  localparam int DEPTH = 4;
  localparam int SKEW  = 3;
  localparam int LEN_W = 16;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   wr_en = 1'b0;
  logic [31:0]            wr_x = '0;
  logic [31:0]            wr_w = '0;
  logic                   full, empty, overflow;
  logic [$clog2(DEPTH):0] fill;
  logic                   go = 1'b0;
  logic [LEN_W-1:0]       len_i = '0;
  logic                   pe_stall = 1'b0;
  logic [31:0]            x_o, w_o;
  logic                   input_start, busy, done;
`ifdef PE_FEEDER_STATS_EN
  logic [31:0]            stall_cycles, starve_cycles;
`endif

  pe_edge_feeder #(.DEPTH(DEPTH), .SKEW(SKEW), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_x(wr_x), .wr_w(wr_w),
    .full(full), .empty(empty), .fill(fill), .overflow(overflow),
    .go(go), .len_i(len_i), .pe_stall(pe_stall),
    .x_o(x_o), .w_o(w_o), .input_start(input_start),
    .busy(busy), .done(done)
`ifdef PE_FEEDER_STATS_EN
    , .stall_cycles(stall_cycles), .starve_cycles(starve_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] w;
  } pair_t;

  // reference model: a queue plus "transfer active / issue allowed from cycle"
  pair_t       q[$];
  bit          m_active, m_done, m_ovf;
  int          m_rem, m_elig, n;
  logic [31:0] m_hx, m_hw;
  longint      m_stall, m_starve;

  bit                     e_stream, e_is, e_busy, e_done;
  bit                     e_full, e_empty, e_ovf;
  logic [31:0]            e_x, e_w;
  logic [$clog2(DEPTH):0] e_fill;

  int tests = 0;
  int fails = 0;

  task automatic set(input bit r, input bit we, input logic [31:0] xx,
                     input logic [31:0] ww, input bit g, input int len,
                     input bit st);
    @(negedge clk);
    rst = r; wr_en = we; wr_x = xx; wr_w = ww;
    go = g; len_i = LEN_W'(len); pe_stall = st;
    #1;
    e_stream = m_active && (n >= m_elig);
    e_is     = e_stream && (q.size() > 0) && !st;
    e_x      = e_is ? q[0].x : m_hx;
    e_w      = e_is ? q[0].w : m_hw;
    e_busy   = m_active;
    e_done   = m_done;
    e_fill   = ($clog2(DEPTH)+1)'(q.size());
    e_full   = (q.size() == DEPTH);
    e_empty  = (q.size() == 0);
    e_ovf    = m_ovf;
  endtask

  task automatic adv();
    bit idle;
    @(posedge clk);
    idle = !m_active && !m_done;
    if (rst) begin
      q.delete();
      m_active = 0; m_done = 0; m_ovf = 0;
      m_hx = '0; m_hw = '0;
      m_stall = 0; m_starve = 0;
    end else begin
      if (e_stream) begin
        if (q.size() == 0) begin
          if (m_starve < 64'hFFFF_FFFF) m_starve++;
        end else if (pe_stall) begin
          if (m_stall < 64'hFFFF_FFFF) m_stall++;
        end
      end
      if (e_is) begin
        m_hx = q[0].x; m_hw = q[0].w;
        void'(q.pop_front());
        m_rem--;
      end
      if (wr_en) begin
        if (q.size() < DEPTH) q.push_back('{x: wr_x, w: wr_w});
        else m_ovf = 1;
      end
      m_done = 0;
      if (e_is && m_rem == 0) begin
        m_active = 0;
        m_done = 1;
      end
      if (idle && go) begin
        m_stall = 0; m_starve = 0;
        if (len_i == 0) m_done = 1;
        else begin
          m_active = 1;
          m_rem = int'(len_i);
          m_elig = n + 1 + SKEW;
        end
      end
    end
    n++;
  endtask

  function automatic bit dut_ok();
    return {input_start, x_o, w_o, busy, done, full, empty, overflow, fill} ===
           {e_is, e_x, e_w, e_busy, e_done, e_full, e_empty, e_ovf, e_fill};
  endfunction

  function automatic string snap();
    return $sformatf(
      "act/exp is=%b/%b x=%h/%h w=%h/%h busy=%b/%b done=%b/%b full=%b/%b empty=%b/%b ovf=%b/%b fill=%0d/%0d",
      input_start, e_is, x_o, e_x, w_o, e_w, busy, e_busy, done, e_done,
      full, e_full, empty, e_empty, overflow, e_ovf, fill, e_fill);
  endfunction

  task automatic test_reset();
    set(1, 0, 0, 0, 0, 0, 0); adv();
    set(0, 0, 0, 0, 0, 0, 0);
    tests++;
    if (x_o !== 32'h0 || w_o !== 32'h0 || input_start !== 1'b0) begin
      fails++;
      $display("FAIL reset_data x=%h w=%h is=%b, need 0/0/0", x_o, w_o, input_start);
    end
    tests++;
    if ({busy, done, empty, full, overflow} !== 5'b00100 || fill !== '0) begin
      fails++;
      $display("FAIL reset_flags busy,done,empty,full,ovf=%b fill=%0d, need 00100 fill=0",
               {busy, done, empty, full, overflow}, fill);
    end
    tests++;
    if (!dut_ok()) begin fails++; $display("FAIL reset_model c%0d %s", n, snap()); end
    adv();
  endtask

  task automatic test_skew();
    logic [31:0] xs [4];
    xs[0] = 32'h3F800000; xs[1] = 32'h40000000;
    xs[2] = 32'h40400000; xs[3] = 32'h40800000;
    for (int i = 0; i < 4; i++) begin
      set(0, 1, xs[i], $urandom, 0, 0, 0);
      tests++;
      if (!dut_ok()) begin fails++; $display("FAIL skew_push c%0d %s", n, snap()); end
      adv();
    end
    set(0, 0, 0, 0, 1, 4, 0);
    tests++;
    if (!dut_ok()) begin fails++; $display("FAIL skew_go c%0d %s", n, snap()); end
    adv();
    for (int k = 1; k <= 10; k++) begin
      set(0, 0, 0, 0, 0, 0, 0);
      tests++;
      if (!dut_ok()) begin fails++; $display("FAIL skew_run c%0d %s", n, snap()); end
      if (k < 4) begin
        tests++;
        if (input_start !== 1'b0) begin
          fails++;
          $display("FAIL skew_early k=%0d input_start=%b need 0", k, input_start);
        end
      end
      if (k == 4) begin
        tests++;
        if (input_start !== 1'b1 || x_o !== 32'h3F800000) begin
          fails++;
          $display("FAIL skew_first is=%b x=%h need 1 3f800000", input_start, x_o);
        end
      end
      if (k == 8) begin
        tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
          fails++;
          $display("FAIL skew_done done=%b busy=%b need 1 0", done, busy);
        end
      end
      adv();
    end
  endtask

  task automatic test_stall();
    int sl = 0, issues = 0, last_i = -1, done_k = -1;
    logic [31:0] last_x = '0;
    for (int i = 0; i < 4; i++) begin
      set(0, 1, $urandom, $urandom, 0, 0, 0); adv();
    end
    set(0, 0, 0, 0, 1, 4, 0); adv();
    for (int k = 0; k < 60 && done_k < 0; k++) begin
      set(0, 0, 0, 0, 0, 0, sl > 0);
      tests++;
      if (!dut_ok()) begin fails++; $display("FAIL stall_run c%0d %s", n, snap()); end
      if (sl > 0) begin
        tests++;
        if (x_o !== last_x || input_start !== 1'b0) begin
          fails++;
          $display("FAIL stall_hold x=%h is=%b need %h 0", x_o, input_start, last_x);
        end
      end
      if (input_start === 1'b1) begin
        issues++; last_i = k; last_x = x_o; sl = 3;
      end else if (sl > 0) sl--;
      if (done === 1'b1) done_k = k;
      adv();
    end
    tests++;
    if (issues != 4 || done_k != last_i + 1) begin
      fails++;
      $display("FAIL stall_count issues=%0d done_k=%0d last=%0d need 4 and last+1",
               issues, done_k, last_i);
    end
  endtask

  task automatic test_overflow();
    int idx = 0;
    bit fin = 0;
    for (int i = 0; i < 5; i++) begin
      set(0, 1, 32'(100 + i), $urandom, 0, 0, 0); adv();
    end
    set(0, 0, 0, 0, 0, 0, 0);
    tests++;
    if (full !== 1'b1 || fill !== 3'd4 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_flags full=%b fill=%0d ovf=%b need 1 4 1", full, fill, overflow);
    end
    adv();
    set(0, 0, 0, 0, 1, 4, 0); adv();
    for (int k = 0; k < 20 && !fin; k++) begin
      set(0, 0, 0, 0, 0, 0, $urandom_range(0, 1));
      tests++;
      if (!dut_ok()) begin fails++; $display("FAIL ovf_run c%0d %s", n, snap()); end
      if (input_start === 1'b1) begin
        tests++;
        if (x_o !== 32'(100 + idx)) begin
          fails++;
          $display("FAIL ovf_order x=%h need %h", x_o, 32'(100 + idx));
        end
        idx++;
      end
      if (done === 1'b1) fin = 1;
      adv();
    end
    tests++;
    if (!fin || idx != 4 || empty !== 1'b1) begin
      fails++;
      $display("FAIL ovf_end fin=%0d issues=%0d empty=%b need 1 4 1", fin, idx, empty);
    end
    set(1, 0, 0, 0, 0, 0, 0); adv();
  endtask

  task automatic test_starve();
    bit fin = 0;
    for (int i = 0; i < 2; i++) begin
      set(0, 1, $urandom, $urandom, 0, 0, 0); adv();
    end
    set(0, 0, 0, 0, 1, 6, 0); adv();
    for (int k = 0; k < 10; k++) begin
      set(0, 0, 0, 0, 0, 0, 0);
      tests++;
      if (!dut_ok()) begin fails++; $display("FAIL starve_wait c%0d %s", n, snap()); end
      adv();
    end
    set(0, 0, 0, 0, 0, 0, 0);
    tests++;
    if (busy !== 1'b1 || empty !== 1'b1 || input_start !== 1'b0) begin
      fails++;
      $display("FAIL starve_busy busy=%b empty=%b is=%b need 1 1 0", busy, empty, input_start);
    end
    adv();
    for (int k = 0; k < 20 && !fin; k++) begin
      set(0, k < 4, $urandom, $urandom, 0, 0, 0);
      tests++;
      if (!dut_ok()) begin fails++; $display("FAIL starve_fill c%0d %s", n, snap()); end
`ifdef PE_FEEDER_STATS_EN
      tests++;
      if (starve_cycles !== 32'(m_starve) || stall_cycles !== 32'(m_stall)) begin
        fails++;
        $display("FAIL starve_stats starve=%0d stall=%0d need %0d %0d",
                 starve_cycles, stall_cycles, m_starve, m_stall);
      end
`endif
      if (done === 1'b1) fin = 1;
      adv();
    end
    tests++;
    if (!fin) begin fails++; $display("FAIL starve_timeout done=0 need 1"); end
  endtask

  task automatic test_len0();
    set(0, 1, $urandom, $urandom, 0, 0, 0); adv();
    set(0, 1, $urandom, $urandom, 0, 0, 0); adv();
    set(0, 0, 0, 0, 1, 0, 0); adv();
    set(0, 0, 0, 0, 0, 0, 0);
    tests++;
    if (done !== 1'b1 || input_start !== 1'b0 || fill !== 3'd2 || busy !== 1'b0) begin
      fails++;
      $display("FAIL len0_done done=%b is=%b fill=%0d busy=%b need 1 0 2 0",
               done, input_start, fill, busy);
    end
    adv();
    set(0, 0, 0, 0, 0, 0, 0);
    tests++;
    if (done !== 1'b0 || fill !== 3'd2) begin
      fails++;
      $display("FAIL len0_after done=%b fill=%0d need 0 2", done, fill);
    end
    tests++;
    if (!dut_ok()) begin fails++; $display("FAIL len0_model c%0d %s", n, snap()); end
    adv();
  endtask

  task automatic test_reset_mid();
    int issues = 0;
    set(1, 0, 0, 0, 0, 0, 0); adv();
    for (int i = 0; i < 5; i++) begin
      set(0, 1, $urandom | 32'h1, $urandom, 0, 0, 0); adv();
    end
    set(0, 0, 0, 0, 1, 8, 0); adv();
    for (int k = 0; k < 20 && issues < 3; k++) begin
      set(0, 0, 0, 0, 0, 0, 0);
      tests++;
      if (!dut_ok()) begin fails++; $display("FAIL rmid_run c%0d %s", n, snap()); end
      if (input_start === 1'b1) issues++;
      adv();
    end
    set(1, 0, 0, 0, 0, 0, 0); adv();
    set(0, 0, 0, 0, 0, 0, 0);
    tests++;
    if (busy !== 1'b0 || fill !== '0 || x_o !== 32'h0 || w_o !== 32'h0 ||
        input_start !== 1'b0 || overflow !== 1'b0 || empty !== 1'b1) begin
      fails++;
      $display("FAIL rmid_clear issues=%0d busy=%b fill=%0d x=%h w=%h is=%b ovf=%b empty=%b",
               issues, busy, fill, x_o, w_o, input_start, overflow, empty);
    end
    adv();
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      set(($urandom % 250) == 0, $urandom_range(0, 1), $urandom, $urandom,
          ($urandom % 6) == 0, $urandom_range(0, 6), ($urandom % 3) == 0);
      tests++;
      if (!dut_ok()) begin fails++; $display("FAIL random c%0d %s", n, snap()); end
`ifdef PE_FEEDER_STATS_EN
      tests++;
      if (starve_cycles !== 32'(m_starve) || stall_cycles !== 32'(m_stall)) begin
        fails++;
        $display("FAIL random_stats starve=%0d stall=%0d need %0d %0d",
                 starve_cycles, stall_cycles, m_starve, m_stall);
      end
`endif
      adv();
    end
  endtask

  initial begin
    m_active = 0; m_done = 0; m_ovf = 0; m_rem = 0; m_elig = 0; n = 0;
    m_hx = '0; m_hw = '0; m_stall = 0; m_starve = 0;
    test_reset();
    test_skew();
    test_stall();
    test_overflow();
    test_starve();
    test_len0();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
